// File: rtl/sid_i2s_tx.sv
// sid_i2s_tx: converts the SID unsigned audio sum to saturated signed PCM, buffers one
// sample and serialises it as a mono-duplicated I2S stream (BCLK, LRCLK, SDATA).
module sid_i2s_tx #(
    parameter int          BCLK_DIV   = 4,
    parameter logic [15:0] DC_OFFSET  = 16'd6144,
    parameter int          GAIN_SHIFT = 2
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata,
    output logic        underrun
);
    localparam int DW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_DIV - 1);

    logic [DW-1:0] r_div_cnt;
    logic          r_bclk, r_lrclk, r_sdata, r_underrun, r_hold_full, r_armed;
    logic [15:0]   r_hold, r_word;
    logic [4:0]    r_bit_cnt;

    logic signed [16:0] w_diff;
    logic signed [19:0] w_scaled;
    logic [15:0]        w_sat, w_word_next;
    logic               w_wrap, w_accept, w_fall, w_load;
    logic [4:0]         w_n, w_n_next;

    always_comb begin
        w_diff      = $signed({1'b0, sample_in}) - $signed({1'b0, DC_OFFSET});
        w_scaled    = {{3{w_diff[16]}}, w_diff} <<< GAIN_SHIFT;
        w_sat       = w_scaled > 20'sd32767 ? 16'h7fff : w_scaled < -20'sd32768 ? 16'h8000 : w_scaled[15:0];
        w_wrap      = r_div_cnt == DIV_MAX;
        w_accept    = sample_valid & ~r_hold_full;
        w_fall      = r_bclk & w_wrap;
        w_n         = r_bit_cnt + 5'd1;
        w_n_next    = w_n + 5'd1;
        w_load      = w_fall & (w_n == 5'd0);
        w_word_next = w_load & r_hold_full ? r_hold : r_word;
    end

    // LRCLK takes bit 4 of the next bit index so it leads each word's MSB by one BCLK
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_div_cnt   <= '0;
            r_bclk      <= 1'b0;
            r_lrclk     <= 1'b0;
            r_sdata     <= 1'b0;
            r_underrun  <= 1'b0;
            r_hold_full <= 1'b0;
            r_armed     <= 1'b0;
            r_hold      <= 16'd0;
            r_word      <= 16'd0;
            r_bit_cnt   <= 5'd31;
        end else begin
            r_div_cnt   <= w_wrap ? '0 : r_div_cnt + 1'b1;
            r_bclk      <= w_wrap ? ~r_bclk : r_bclk;
            r_underrun  <= w_load & ~r_hold_full & r_armed;
            r_hold_full <= w_accept | (r_hold_full & ~w_load);
            if (w_accept) begin
                r_hold  <= w_sat;
                r_armed <= 1'b1;
            end
            if (w_fall) begin
                r_bit_cnt <= w_n;
                r_word    <= w_word_next;
                r_sdata   <= w_word_next[~w_n[3:0]];
                r_lrclk   <= w_n_next[4];
            end
        end
    end

    assign sample_ready = ~r_hold_full;
    assign i2s_bclk     = r_bclk;
    assign i2s_lrclk    = r_lrclk;
    assign i2s_sdata    = r_sdata;
    assign underrun     = r_underrun;
endmodule

// File: tb/tb_sid_i2s_tx.sv
// tb_sid_i2s_tx: three instances (DIV/GAIN 2/2, 1/3, 1/0) driven with directed and random
// samples; a monitor deserialises each I2S stream and checks it against a queue-based model.
module tb_sid_i2s_tx;
    localparam int DIV [3] = '{2, 1, 1};
    localparam int GS  [3] = '{2, 3, 0};

    typedef struct { logic [15:0] w; int t; } sb_t;
    typedef struct { logic [15:0] d; int gap; } st_t;

    logic        clk = 0, n_reset = 0;
    logic [15:0] din [3];
    logic [2:0]  vld = '0;
    wire  [2:0]  rdy, bclk, lr, sd, ur;
    int          cyc = 0, total = 0, bad = 0;
    sb_t         sbq [3][$];
    st_t         stq [3][$];
    int          gapc [3];
    bit          acc [3];
    bit          fin = 0, fin_done = 0;

    int          lb [3], ll [3], nb [3];
    bit          pb [3], plr [3], ld_nx [3], in_fr [3], armed [3];
    bit          fall, rise, exp_ur;
    logic [15:0] cur [3];
    logic [31:0] sh [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sid_i2s_tx #(.BCLK_DIV(2), .GAIN_SHIFT(2)) u0 (.clk(clk), .n_reset(n_reset), .sample_in(din[0]),
        .sample_valid(vld[0]), .sample_ready(rdy[0]), .i2s_bclk(bclk[0]), .i2s_lrclk(lr[0]),
        .i2s_sdata(sd[0]), .underrun(ur[0]));
    sid_i2s_tx #(.BCLK_DIV(1), .GAIN_SHIFT(3)) u1 (.clk(clk), .n_reset(n_reset), .sample_in(din[1]),
        .sample_valid(vld[1]), .sample_ready(rdy[1]), .i2s_bclk(bclk[1]), .i2s_lrclk(lr[1]),
        .i2s_sdata(sd[1]), .underrun(ur[1]));
    sid_i2s_tx #(.BCLK_DIV(1), .GAIN_SHIFT(0)) u2 (.clk(clk), .n_reset(n_reset), .sample_in(din[2]),
        .sample_valid(vld[2]), .sample_ready(rdy[2]), .i2s_bclk(bclk[2]), .i2s_lrclk(lr[2]),
        .i2s_sdata(sd[2]), .underrun(ur[2]));

    function automatic logic [15:0] conv(input int s, input int g);
        int d;
        d = (s - 6144) * (1 << g);
        d = d > 32767 ? 32767 : d < -32768 ? -32768 : d;
        return d[15:0];
    endfunction

    task automatic chk(input string name, input int k, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[%0d] cyc=%0d got=%0h expected=%0h", name, k, cyc, act, exp);
        end
    endtask

    task automatic add(input int k, input logic [15:0] d, input int gap);
        st_t e;
        e.d = d;
        e.gap = gap;
        stq[k].push_back(e);
    endtask

    // A transfer happens at the posedge after a negedge where valid and ready are both high
    task automatic step();
        sb_t e;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (acc[k]) begin
                vld[k] = 0;
                acc[k] = 0;
            end
            if (!vld[k] && stq[k].size() > 0) begin
                if (gapc[k] >= stq[k][0].gap) begin
                    din[k] = stq[k][0].d;
                    stq[k].pop_front();
                    vld[k] = 1;
                    gapc[k] = 0;
                end else gapc[k]++;
            end
            if (vld[k] && rdy[k]) begin
                e.w = conv(int'(din[k]), GS[k]);
                e.t = cyc + 1;
                sbq[k].push_back(e);
                acc[k] = 1;
            end
        end
    endtask

    function automatic bit busy();
        for (int k = 0; k < 3; k++) if (stq[k].size() > 0 || sbq[k].size() > 0 || vld[k]) return 1;
        return 0;
    endfunction

    task automatic drain();
        for (int i = 0; i < 20000 && busy(); i++) step();
        repeat (300) step();
    endtask

    function automatic logic [15:0] rnd();
        int r;
        r = $urandom_range(0, 7);
        return r == 0 ? 16'd0 : r == 1 ? 16'd12285 : r == 2 ? 16'd6144 : r == 3 ? 16'($urandom_range(0, 65535))
                      : 16'($urandom_range(0, 12285));
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!n_reset) begin
                chk("reset_outputs", k, {rdy[k], bclk[k], lr[k], sd[k], ur[k]}, 5'b10000);
                sbq[k].delete();
                cur[k] = 0; ld_nx[k] = 1; in_fr[k] = 0; armed[k] = 0;
                pb[k] = 0; plr[k] = 0; lb[k] = -1; ll[k] = -1; nb[k] = 0;
            end else begin
                fall = pb[k] && !bclk[k];
                rise = !pb[k] && bclk[k];
                exp_ur = 0;
                if (bclk[k] != pb[k]) begin
                    if (lb[k] >= 0) chk("bclk_half", k, cyc - lb[k], DIV[k]);
                    lb[k] = cyc;
                end
                if (lr[k] != plr[k]) begin
                    if (ll[k] >= 0) chk("lrclk_half", k, cyc - ll[k], 32 * DIV[k]);
                    chk("lrclk_on_fall", k, fall, 1);
                    ll[k] = cyc;
                end
                // A frame starts on the first BCLK fall after reset or after LRCLK falls
                if (fall && ld_nx[k]) begin
                    if (in_fr[k]) chk("frame_len", k, nb[k], 32);
                    if (sbq[k].size() > 0 && sbq[k][0].t < cyc) begin
                        cur[k] = sbq[k][0].w;
                        sbq[k].pop_front();
                        armed[k] = 1;
                    end else exp_ur = armed[k];
                    in_fr[k] = 1; nb[k] = 0; ld_nx[k] = 0;
                end
                if (fall && plr[k] && !lr[k]) ld_nx[k] = 1;
                if (fall || ur[k]) chk("underrun", k, ur[k], exp_ur);
                if (rise && in_fr[k] && nb[k] < 32) begin
                    chk("lrclk_slot", k, lr[k], nb[k] >= 15 && nb[k] <= 30);
                    sh[k] = {sh[k][30:0], sd[k]};
                    nb[k]++;
                    if (nb[k] == 32) chk("frame_data", k, sh[k], {cur[k], cur[k]});
                end
                chk("ready", k, rdy[k], !(sbq[k].size() > 0 && sbq[k][0].t <= cyc));
                pb[k] = bclk[k];
                plr[k] = lr[k];
            end
        end
        if (fin && !fin_done) begin
            for (int k = 0; k < 3; k++) chk("drained", k, sbq[k].size(), 0);
            fin_done = 1;
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            din[k] = 0; gapc[k] = 0; acc[k] = 0;
        end
        repeat (4) @(negedge clk);
        n_reset = 1;
        add(0, 16'd6144, 0); add(0, 16'd12285, 0); add(0, 16'h1900, 0);
        add(1, 16'd12285, 0); add(1, 16'd0, 0);
        add(2, 16'd0, 0); add(2, 16'd12285, 0);
        repeat (1000) step();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < (k == 0 ? 16 : 30); i++)
                add(k, rnd(), $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 200)) : 0);
        drain();
        for (int k = 0; k < 3; k++) for (int i = 0; i < 4; i++) add(k, rnd(), 0);
        repeat (150) step();
        @(posedge clk);
        #1 n_reset = 0;
        for (int k = 0; k < 3; k++) begin
            vld[k] = 0; acc[k] = 0; gapc[k] = 0;
            stq[k].delete();
        end
        repeat (3) @(negedge clk);
        n_reset = 1;
        repeat (400) step();
        for (int k = 0; k < 3; k++) for (int i = 0; i < 3; i++) add(k, rnd(), int'($urandom_range(0, 40)));
        drain();
        fin = 1;
        for (int i = 0; i < 10 && !fin_done; i++) @(negedge clk);
        if (!fin_done) begin
            total++;
            bad++;
            $display("FAIL final_check got=timeout expected=done");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sid_i2s_tx.md
Name: sid_i2s_tx

Overview:
Downstream output stage for the SID core. It consumes the core's 16-bit unsigned audio sum (three 12-bit voices, 0..12285) and converts it to signed PCM by DC-offset removal, gain shift and saturation. It buffers one sample and serialises it as a standard I2S mono-duplicated stereo stream (BCLK, LRCLK, SDATA) for an external DAC. Ready/valid handshake on the input side, one sample per I2S frame.

Parameters:
BCLK_DIV, 4, clk cycles per BCLK half-period (>=1); frame = 64*BCLK_DIV clk cycles
DC_OFFSET, 16'd6144, unsigned value subtracted from sample_in to centre it on zero
GAIN_SHIFT, 2, left shift (0..3) applied after offset removal, before saturation

Ports:
clk  input  1  system clock
n_reset  input  1  asynchronous active-low reset
sample_in  input  16  unsigned audio sample from SID core
sample_valid  input  1  sample_in valid this cycle
sample_ready  output  1  holding register empty; transfer when valid & ready
i2s_bclk  output  1  bit clock, registered
i2s_lrclk  output  1  word select, 0 = left, 1 = right, registered
i2s_sdata  output  1  serial data, MSB first, registered
underrun  output  1  one-clk pulse when a frame starts with no new sample

Behaviour:
- Reset (async, n_reset low): i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, underrun=0, holding empty (sample_ready=1), frame word=0, div_cnt=0, bit_cnt=31, armed=0. Mid-frame reset aborts the frame immediately; no partial word resumes.
- Input conversion (on accepted transfer, registered into holding reg): diff = {1'b0,sample_in} - {1'b0,DC_OFFSET} as 17-bit signed; scaled = diff <<< GAIN_SHIFT in 20-bit signed; hold = saturate to [-32768, 32767]. Sets hold_full, sets armed.
- sample_ready = !hold_full, driven from a register (no combinational path from sample_valid).
- Divider: div_cnt counts 0..BCLK_DIV-1; on wrap i2s_bclk toggles. A toggle 1->0 is a "falling event"; all serial state changes only on falling events.
- At each falling event: n = (bit_cnt+1) mod 32 becomes bit_cnt.
  - n==0 (frame load): if hold_full, frame word <= hold, hold_full <= 0; else frame word unchanged (repeat) and, if armed, underrun pulses 1 clk.
  - i2s_sdata <= word[15 - (n mod 16)], using the newly loaded word when n==0.
  - i2s_lrclk <= bit 4 of ((n+1) mod 32): LRCLK rises with left LSB (n=15), falls with right LSB (n=31), i.e. one BCLK ahead of each MSB (standard I2S).
- Both slots carry the same word (mono duplicated).
- Simultaneous write and frame load while holding empty: load sees empty (repeat + underrun if armed); the written sample lands in holding for the next frame. No bypass.
- Holding full and frame load in same cycle: ready was already 0, so no write can collide; hold_full clears and ready rises next cycle.
- Sample rate = f_clk / (64*BCLK_DIV); upstream must supply at most one sample per frame, extra valids are stalled by ready=0.

Test Plan:
- Reset: hold n_reset low mid-stream -> all outputs 0 within the same cycle, sample_ready=1, no underrun before first accepted sample.
- Conversion, BCLK_DIV=2, GAIN_SHIFT=2: write 6144 -> both slots serialise 0x0000; write 12285 -> 0x5FF4, MSB at first falling BCLK after LRCLK falls, LSB coincident with LRCLK rise.
- Saturation, GAIN_SHIFT=3: write 12285 -> 0x7FFF; write 0 -> 0x8000; with GAIN_SHIFT=0, write 0 -> 0xE800.
- Underrun: accept one sample 0x1900 (-> 0x0400 at GAIN_SHIFT=2), supply nothing further -> next frame repeats 0x0400 and underrun is high for exactly 1 clk at n==0 falling event.
- Backpressure: sample_valid held high with incrementing data -> exactly one transfer per 128-clk frame (BCLK_DIV=2), ready low from accept until the frame load, serial words match the accepted sequence without loss.
- Timing: BCLK_DIV=1 -> i2s_bclk period 2 clk, LRCLK period 64 clk, 50% duty for both.
